// File: rtl/zbus_sink.sv
// zbus_sink: receiving end of a zbus link with a selectable ack policy, a receive FIFO,
// a transfer counter and sticky source-protocol error flags.
//   state | meaning
//   IDLE  | no ack; cfg_mode/cfg_dly sampled here
//   WAIT  | DELAY policy, dcnt counting down to terminal count
//   ACK   | ack_en driven by the latched policy
module zbus_sink #(
  parameter int          BW    = 1,
  parameter int          DEPTH = 4,
  parameter int          DW    = 8,
  parameter logic [15:0] SEED  = 16'hace1
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          z_vld,
  input  logic [BW-1:0] z_bus,
  output logic          z_ack,
  input  logic [1:0]    cfg_mode,
  input  logic [DW-1:0] cfg_dly,
  input  logic          rd_en,
  output logic          rd_vld,
  output logic [BW-1:0] rd_dat,
  output logic [31:0]   cnt,
  input  logic          err_clr,
  output logic          err_drop,
  output logic          err_hold
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] M_ALWAYS = 2'd0;
  localparam logic [1:0] M_DELAY  = 2'd1;
  localparam logic [1:0] M_RANDOM = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] dcnt, dcnt_d;
  logic          ack_en, ack_en_d;
  logic [15:0]   lfsr, lfsr_d;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [BW-1:0] mem [DEPTH];
  logic          push, pop, full, empty;
  logic          pend_q;
  logic [BW-1:0] bus_q;

  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty  = (wr_ptr == rd_ptr);
  assign z_ack  = ack_en & ~full;
  assign push   = z_vld & z_ack;
  assign pop    = rd_en & ~empty;
  assign rd_vld = ~empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign lfsr_d = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  always_comb begin
    state_d  = state;
    mode_d   = (state == IDLE) ? cfg_mode : mode_q;
    dcnt_d   = dcnt;
    ack_en_d = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_mode == M_DELAY) begin
          if (z_vld) begin
            state_d = WAIT;
            dcnt_d  = cfg_dly;
          end
        end else begin
          state_d = ACK;
        end
      end
      WAIT: begin
        if (!z_vld)             state_d = IDLE;
        else if (dcnt == '0)    state_d = ACK;
        else                    dcnt_d  = dcnt - DW'(1);
      end
      ACK: begin
        // Non-DELAY policies only change when the source is not mid-transfer.
        if (mode_q == M_DELAY) begin
          if (push || !z_vld) state_d = IDLE;
        end else if ((cfg_mode != mode_q) && !z_vld) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACK) begin
      case (mode_d)
        M_ALWAYS, M_DELAY: ack_en_d = 1'b1;
        M_RANDOM:          ack_en_d = lfsr_d[0];
        default:           ack_en_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge z_clk) begin
    if (!z_rst) begin
      state    <= IDLE;
      mode_q   <= M_ALWAYS;
      dcnt     <= '0;
      ack_en   <= 1'b0;
      lfsr     <= SEED;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      pend_q   <= 1'b0;
      bus_q    <= '0;
      err_drop <= 1'b0;
      err_hold <= 1'b0;
    end else begin
      state  <= state_d;
      mode_q <= mode_d;
      dcnt   <= dcnt_d;
      ack_en <= ack_en_d;
      lfsr   <= lfsr_d;
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
        cnt    <= cnt + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      pend_q <= z_vld & ~z_ack;
      bus_q  <= z_bus;
      // A new violation in the same cycle as err_clr keeps the flag set.
      if (pend_q && !z_vld)                    err_drop <= 1'b1;
      else if (err_clr)                        err_drop <= 1'b0;
      if (pend_q && z_vld && (z_bus != bus_q)) err_hold <= 1'b1;
      else if (err_clr)                        err_hold <= 1'b0;
    end
  end

  always_ff @(posedge z_clk) begin
    if (z_rst && push) mem[wr_ptr[AW-1:0]] <= z_bus;
  end
endmodule

// File: tb/tb_zbus_sink.sv
// Bench for zbus_sink: directed scenarios per ack policy plus a randomized source run
// checked against a queue scoreboard and an LFSR-sequence model of the RANDOM policy.
module tb_zbus_sink;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam logic [15:0] SEED = 16'hace1;
  localparam logic [1:0] M_ALWAYS = 2'd0;
  localparam logic [1:0] M_DELAY  = 2'd1;
  localparam logic [1:0] M_RANDOM = 2'd2;
  localparam logic [1:0] M_STALL  = 2'd3;

  logic          z_clk = 1'b0;
  logic          z_rst, z_vld, z_ack, rd_en, rd_vld, err_clr, err_drop, err_hold;
  logic [BW-1:0] z_bus, rd_dat;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_dly;
  logic [31:0]   cnt;
  int            n_run  = 0;
  int            n_fail = 0;

  always #5 z_clk = ~z_clk;

  zbus_sink #(.BW(BW), .DEPTH(DEPTH), .DW(DW), .SEED(SEED)) dut (
    .z_clk(z_clk), .z_rst(z_rst), .z_vld(z_vld), .z_bus(z_bus), .z_ack(z_ack),
    .cfg_mode(cfg_mode), .cfg_dly(cfg_dly), .rd_en(rd_en), .rd_vld(rd_vld),
    .rd_dat(rd_dat), .cnt(cnt), .err_clr(err_clr), .err_drop(err_drop), .err_hold(err_hold)
  );

  task automatic tick();
    @(posedge z_clk);
    #1;
  endtask

  task automatic do_reset();
    z_rst = 1'b0; z_vld = 1'b0; z_bus = '0; rd_en = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    z_rst = 1'b1;
  endtask

  // Holds z_vld/z_bus until the handshake edge has passed; z_vld stays high afterwards.
  task automatic send(input logic [BW-1:0] w, input int budget, output bit ok);
    z_vld = 1'b1; z_bus = w; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (z_ack) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  task automatic test_reset();
    cfg_mode = M_ALWAYS; cfg_dly = '0;
    do_reset();
    n_run++; if (z_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", z_ack); end
    n_run++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_rd_vld: got %b expected 0", rd_vld); end
    n_run++; if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_run++; if ({err_drop, err_hold} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b%b expected 00", err_drop, err_hold); end
  endtask

  task automatic test_always();
    logic [BW-1:0] wv [3];
    bit ok;
    wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33;
    cfg_mode = M_ALWAYS;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(wv[i], 10, ok);
      n_run++; if (!ok) begin n_fail++; $display("FAIL always_ack_timeout: word %0d got no ack, expected ack", i); end
    end
    z_vld = 1'b0;
    n_run++; if (cnt !== 32'd3) begin n_fail++; $display("FAIL always_cnt: got %0d expected 3", cnt); end
    for (int i = 0; i < 3; i++) begin
      n_run++; if (rd_dat !== wv[i] || rd_vld !== 1'b1) begin n_fail++; $display("FAIL always_pop: got %h/vld %b expected %h/vld 1", rd_dat, rd_vld, wv[i]); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_run++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL always_empty: got %b expected 0", rd_vld); end
  endtask

  task automatic test_delay();
    logic [BW-1:0] w;
    int dly;
    cfg_mode = M_DELAY; cfg_dly = '0;
    do_reset();
    for (int it = 0; it < 4; it++) begin
      dly = (it == 0) ? 3 : (it == 1) ? 0 : int'($urandom_range(1, 7));
      w   = (it == 0) ? 8'hA5 : 8'($urandom);
      cfg_dly = DW'(dly); z_vld = 1'b1; z_bus = w;
      n_run++; if (z_ack !== 1'b0) begin n_fail++; $display("FAIL delay_ack_rise: dly %0d got %b expected 0", dly, z_ack); end
      // edge e=1 sees z_vld; ack is up after edge dly+2 and the transfer happens on the next edge
      for (int e = 1; e <= dly + 3; e++) begin
        tick();
        n_run++; if (z_ack !== (e == dly + 2)) begin n_fail++; $display("FAIL delay_ack_timing: dly %0d edge %0d got %b expected %b", dly, e, z_ack, (e == dly + 2)); end
      end
      z_vld = 1'b0;
      tick();
      n_run++; if (cnt !== 32'(it + 1)) begin n_fail++; $display("FAIL delay_cnt: got %0d expected %0d", cnt, it + 1); end
      n_run++; if (rd_vld !== 1'b1 || rd_dat !== w) begin n_fail++; $display("FAIL delay_data: got %h/vld %b expected %h/vld 1", rd_dat, rd_vld, w); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_run++; if ({err_drop, err_hold} !== 2'b00) begin n_fail++; $display("FAIL delay_err: got %b%b expected 00", err_drop, err_hold); end
  endtask

  task automatic test_full();
    logic [BW-1:0] wv [6];
    int   i, acks, occ;
    bit   xfer, ok;
    for (int j = 0; j < 6; j++) wv[j] = 8'hA0 + 8'(j);
    cfg_mode = M_ALWAYS;
    do_reset();
    i = 0; acks = 0; occ = 0;
    for (int c = 0; c < 12; c++) begin
      z_vld = 1'b1; z_bus = wv[i];
      if (occ == DEPTH) begin
        n_run++; if (z_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack: cycle %0d got %b expected 0", c, z_ack); end
      end
      xfer = z_ack;
      tick();
      if (xfer) begin i++; occ++; acks++; end
    end
    n_run++; if (acks !== DEPTH) begin n_fail++; $display("FAIL full_acks: got %0d expected %0d", acks, DEPTH); end
    n_run++; if (cnt !== 32'(DEPTH)) begin n_fail++; $display("FAIL full_cnt: got %0d expected %0d", cnt, DEPTH); end
    n_run++; if (rd_dat !== wv[0]) begin n_fail++; $display("FAIL full_head: got %h expected %h", rd_dat, wv[0]); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_run++; if (z_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack_after_pop: got %b expected 1", z_ack); end
    tick();
    z_vld = 1'b0;
    n_run++; if (cnt !== 32'(DEPTH + 1)) begin n_fail++; $display("FAIL full_cnt5: got %0d expected %0d", cnt, DEPTH + 1); end
    for (int j = 1; j <= DEPTH; j++) begin
      n_run++; if (rd_vld !== 1'b1 || rd_dat !== wv[j]) begin n_fail++; $display("FAIL full_drain: got %h/vld %b expected %h/vld 1", rd_dat, rd_vld, wv[j]); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    n_run++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %b expected 0", rd_vld); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    n_run++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty: got %b expected 0", rd_vld); end
    send(8'h5A, 10, ok);
    z_vld = 1'b0;
    n_run++; if (!ok || rd_vld !== 1'b1 || rd_dat !== 8'h5A) begin n_fail++; $display("FAIL full_after_empty_pop: got %h/vld %b expected 5a/vld 1", rd_dat, rd_vld); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_stall_err();
    bit ok;
    cfg_mode = M_STALL;
    do_reset();
    z_vld = 1'b1; z_bus = 8'h3C;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_run++; if (z_ack !== 1'b0) begin n_fail++; $display("FAIL stall_ack: cycle %0d got %b expected 0", c, z_ack); end
    end
    z_vld = 1'b0; tick();
    n_run++; if ({err_drop, err_hold} !== 2'b10) begin n_fail++; $display("FAIL stall_drop: got %b%b expected 10", err_drop, err_hold); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_run++; if (err_drop !== 1'b0) begin n_fail++; $display("FAIL stall_drop_clr: got %b expected 0", err_drop); end
    z_vld = 1'b1; z_bus = 8'h3C; tick();
    z_bus = 8'h3D; tick();
    n_run++; if ({err_drop, err_hold} !== 2'b01) begin n_fail++; $display("FAIL stall_hold: got %b%b expected 01", err_drop, err_hold); end
    z_bus = 8'h3E; err_clr = 1'b1; tick();
    n_run++; if (err_hold !== 1'b1) begin n_fail++; $display("FAIL stall_set_wins: got %b expected 1", err_hold); end
    tick(); err_clr = 1'b0;
    n_run++; if (err_hold !== 1'b0) begin n_fail++; $display("FAIL stall_hold_clr: got %b expected 0", err_hold); end
    z_vld = 1'b0; cfg_mode = M_ALWAYS; tick();
    n_run++; if (err_drop !== 1'b1) begin n_fail++; $display("FAIL stall_drop2: got %b expected 1", err_drop); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    send(8'h5C, 10, ok);
    z_vld = 1'b0;
    n_run++; if (!ok || cnt !== 32'd1 || rd_dat !== 8'h5C) begin n_fail++; $display("FAIL stall_exit: got ok %b cnt %0d dat %h expected ok 1 cnt 1 dat 5c", ok, cnt, rd_dat); end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
  endtask

  task automatic test_random();
    logic [BW-1:0] q [$];
    logic [BW-1:0] w;
    logic [15:0]   lf;
    int            k, nx, cyc;
    bit            exp_ack, xfer, popping;
    cfg_mode = M_RANDOM;
    do_reset();
    lf = SEED; k = 0; nx = 0; cyc = 0;
    while (nx < 1000 && cyc < 20000) begin
      if (!z_vld && $urandom_range(0, 3) != 0) begin z_vld = 1'b1; z_bus = 8'($urandom); end
      rd_en = ($urandom_range(0, 2) != 0);
      exp_ack = (k >= 1) && lf[0] && (q.size() < DEPTH);
      n_run++; if (z_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack: cycle %0d got %b expected %b", cyc, z_ack, exp_ack); end
      n_run++; if (rd_vld !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_rd_vld: cycle %0d got %b expected %b", cyc, rd_vld, (q.size() != 0)); end
      popping = rd_en && (q.size() != 0);
      if (popping) begin
        n_run++; if (rd_dat !== q[0]) begin n_fail++; $display("FAIL rand_data: cycle %0d got %h expected %h", cyc, rd_dat, q[0]); end
      end
      xfer = z_vld && exp_ack;
      w = z_bus;
      tick();
      k++; cyc++; lf = lfsr_next(lf);
      if (popping) q.delete(0);
      if (xfer) begin q.push_back(w); nx++; z_vld = 1'b0; end
    end
    z_vld = 1'b0;
    n_run++; if (nx != 1000) begin n_fail++; $display("FAIL rand_timeout: got %0d transfers expected 1000", nx); end
    for (int c = 0; c < 4 * DEPTH && q.size() != 0; c++) begin
      n_run++; if (rd_vld !== 1'b1 || rd_dat !== q[0]) begin n_fail++; $display("FAIL rand_drain: got %h/vld %b expected %h/vld 1", rd_dat, rd_vld, q[0]); end
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      q.delete(0);
    end
    n_run++; if (rd_vld !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %b expected 0", rd_vld); end
    n_run++; if (cnt !== 32'd1000) begin n_fail++; $display("FAIL rand_cnt: got %0d expected 1000", cnt); end
    n_run++; if ({err_drop, err_hold} !== 2'b00) begin n_fail++; $display("FAIL rand_err: got %b%b expected 00", err_drop, err_hold); end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    cfg_mode = M_DELAY; cfg_dly = '0;
    do_reset();
    send(8'h71, 10, ok1);
    send(8'h72, 10, ok2);
    z_bus = 8'h73; cfg_dly = 8'd20;
    for (int c = 0; c < 4; c++) tick();
    n_run++; if (!ok1 || !ok2 || z_ack !== 1'b0 || rd_vld !== 1'b1 || cnt !== 32'd2) begin n_fail++; $display("FAIL mid_setup: got ack %b vld %b cnt %0d expected ack 0 vld 1 cnt 2", z_ack, rd_vld, cnt); end
    z_rst = 1'b0; tick();
    n_run++; if (z_ack !== 1'b0 || rd_vld !== 1'b0 || cnt !== 32'd0) begin n_fail++; $display("FAIL mid_reset: got ack %b vld %b cnt %0d expected ack 0 vld 0 cnt 0", z_ack, rd_vld, cnt); end
    z_rst = 1'b1; cfg_dly = 8'd1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_run++; if (z_ack !== (e == 3)) begin n_fail++; $display("FAIL mid_resume_ack: edge %0d got %b expected %b", e, z_ack, (e == 3)); end
    end
    z_vld = 1'b0;
    n_run++; if (cnt !== 32'd1 || rd_dat !== 8'h73 || rd_vld !== 1'b1) begin n_fail++; $display("FAIL mid_resume_data: got cnt %0d dat %h expected cnt 1 dat 73", cnt, rd_dat); end
  endtask

  initial begin
    z_rst = 1'b0; z_vld = 1'b0; z_bus = '0; cfg_mode = M_ALWAYS; cfg_dly = '0;
    rd_en = 1'b0; err_clr = 1'b0;
    test_reset();
    test_always();
    test_delay();
    test_full();
    test_stall_err();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
